// File: rtl/pipe_decode.sv
// Pipelined one-hot decoder. Wide decodes are split into groups of six lines:
// a recursive instance selects the group while the sub-index travels alongside.
module pipe_decode #(
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [$clog2(WIDTH)-1:0] in_idx,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     out_err
);

  function automatic int calc_lat(input int w);
    int l;
    int r;
    l = 1;
    r = w;
    while (r > 6) begin
      r = (r + 5) / 6;
      l++;
    end
    return l;
  endfunction

  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;
  logic             range_err;

  assign range_err = in_valid && ({1'b0, in_idx} >= (IW+1)'(WIDTH));

  generate
    if (WIDTH <= 6) begin : g_leaf
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
        assign out_d[gi] = in_valid & ~range_err & (in_idx == IW'(gi));
      end
      assign out_valid_d = in_valid;
      assign out_err_d   = range_err;
    end else begin : g_tree
      localparam int G     = (WIDTH + 5) / 6;
      localparam int GW    = $clog2(G);
      localparam int LAT_G = calc_lat(G);

      logic [G-1:0]  grp_sel;
      logic          grp_valid;
      logic          grp_err;
      logic [GW-1:0] grp_idx;
      // {range error, sub-index} carried in step with the group-select pipeline
      logic [3:0]    dly_q [LAT_G];

      // Out-of-range indices may truncate onto a real group; the delayed error bit masks that.
      assign grp_idx = GW'(in_idx / 6);

      pipe_decode #(
        .WIDTH(G)
      ) u_grp (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_idx   (grp_idx),
        .out      (grp_sel),
        .out_valid(grp_valid),
        .out_err  (grp_err)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < LAT_G; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= {range_err, 3'(in_idx % 6)};
          for (int i = 1; i < LAT_G; i++) dly_q[i] <= dly_q[i-1];
        end
      end

      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
        assign out_d[gi] = grp_sel[gi/6] & ~dly_q[LAT_G-1][3]
                           & (dly_q[LAT_G-1][2:0] == 3'(gi % 6));
      end
      assign out_valid_d = grp_valid;
      assign out_err_d   = dly_q[LAT_G-1][3] | grp_err;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_pipe_decode.sv
// Bench for pipe_decode: several widths side by side, directed vectors plus
// a random run checked against a cycle-history reference model.
module tb_pipe_decode;

  localparam int NI = 9;
  localparam int W_TAB [NI] = '{2, 6, 7, 10, 36, 37, 40, 216, 217};
  localparam int I_W6  = 1;
  localparam int I_W10 = 3;
  localparam int I_W40 = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] raw = '0;

  logic [255:0] out_all [NI];
  logic         ov_all  [NI];
  logic         oe_all  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int W  = W_TAB[gi];
      localparam int IW = $clog2(W);
      logic [W-1:0] o;
      logic         ov;
      logic         oe;
      pipe_decode #(.WIDTH(W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_idx   (raw[IW-1:0]),
        .out      (o),
        .out_valid(ov),
        .out_err  (oe)
      );
      assign out_all[gi] = 256'(o);
      assign ov_all[gi]  = ov;
      assign oe_all[gi]  = oe;
    end
  endgenerate

  int checks = 0;
  int errors = 0;
  int e = 0;

  bit          h_rst [8192];
  bit          h_v   [8192];
  logic [15:0] h_raw [8192];

  function automatic int tb_lat(input int w);
    if (w <= 6) return 1;
    return 1 + tb_lat((w + 5) / 6);
  endfunction

  // Output after edge n reflects the input at edge n-LAT+1, unless reset hit it on the way.
  task automatic model(input int i, input int n, output logic [255:0] eo,
                       output logic ev, output logic ee);
    int w, lat, s, idx;
    w   = W_TAB[i];
    lat = tb_lat(w);
    s   = n - lat + 1;
    eo  = '0;
    ev  = 1'b0;
    ee  = 1'b0;
    if (s < 0) return;
    for (int m = s; m <= n; m++) if (h_rst[m]) return;
    if (!h_v[s]) return;
    idx = int'(h_raw[s]) % (1 << $clog2(w));
    ev = 1'b1;
    if (idx >= w) ee = 1'b1;
    else eo[idx] = 1'b1;
  endtask

  task automatic check_all(input int n);
    logic [255:0] eo;
    logic         ev, ee;
    for (int i = 0; i < NI; i++) begin
      model(i, n, eo, ev, ee);
      checks++;
      if (out_all[i] !== eo || ov_all[i] !== ev || oe_all[i] !== ee) begin
        errors++;
        $display("FAIL model w=%0d edge=%0d: got out=%h v=%b e=%b, expected out=%h v=%b e=%b",
                 W_TAB[i], n, out_all[i], ov_all[i], oe_all[i], eo, ev, ee);
      end
      checks++;
      if ($countones(out_all[i]) > 1) begin
        errors++;
        $display("FAIL onehot w=%0d edge=%0d: got popcount=%0d, expected <= 1",
                 W_TAB[i], n, $countones(out_all[i]));
      end
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [15:0] x);
    rst      = r;
    in_valid = v;
    raw      = x;
    h_rst[e] = r;
    h_v[e]   = v;
    h_raw[e] = x;
    @(posedge clk);
    e++;
    @(negedge clk);
    check_all(e - 1);
  endtask

  task automatic expect_out(input string name, input int inst, input logic [255:0] eo,
                            input logic ev, input logic ee);
    checks++;
    if (out_all[inst] !== eo || ov_all[inst] !== ev || oe_all[inst] !== ee) begin
      errors++;
      $display("FAIL %s w=%0d: got out=%h v=%b e=%b, expected out=%h v=%b e=%b",
               name, W_TAB[inst], out_all[inst], ov_all[inst], oe_all[inst], eo, ev, ee);
    end
  endtask

  typedef struct {
    int           inst;
    bit           r;
    bit           v;
    int           idx;
    bit           chk;
    logic [255:0] eo;
    bit           ev;
    bit           ee;
  } vec_t;

  function automatic vec_t mk(input int inst, input bit r, input bit v, input int idx,
                              input bit chk, input logic [255:0] eo, input bit ev,
                              input bit ee);
    vec_t t;
    t.inst = inst; t.r = r; t.v = v; t.idx = idx;
    t.chk = chk; t.eo = eo; t.ev = ev; t.ee = ee;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    // Reset, then WIDTH=10 (LAT=2): idx 7, 12 (error), then 0, 9, 3 back to back
    tbl.push_back(mk(I_W10, 1, 0, 0,  1, 256'h0,   0, 0));
    tbl.push_back(mk(I_W10, 1, 1, 5,  1, 256'h0,   0, 0));
    tbl.push_back(mk(I_W10, 0, 1, 7,  1, 256'h0,   0, 0));
    tbl.push_back(mk(I_W10, 0, 1, 12, 1, 256'h080, 1, 0));
    tbl.push_back(mk(I_W10, 0, 1, 0,  1, 256'h0,   1, 1));
    tbl.push_back(mk(I_W10, 0, 1, 9,  1, 256'h001, 1, 0));
    tbl.push_back(mk(I_W10, 0, 1, 3,  1, 256'h200, 1, 0));
    tbl.push_back(mk(I_W10, 0, 0, 9,  1, 256'h008, 1, 0));
    tbl.push_back(mk(I_W10, 0, 0, 9,  1, 256'h0,   0, 0));
    // WIDTH=6 (LAT=1) sweep 0..7
    tbl.push_back(mk(I_W6, 0, 1, 0, 1, 256'h01, 1, 0));
    tbl.push_back(mk(I_W6, 0, 1, 1, 1, 256'h02, 1, 0));
    tbl.push_back(mk(I_W6, 0, 1, 2, 1, 256'h04, 1, 0));
    tbl.push_back(mk(I_W6, 0, 1, 3, 1, 256'h08, 1, 0));
    tbl.push_back(mk(I_W6, 0, 1, 4, 1, 256'h10, 1, 0));
    tbl.push_back(mk(I_W6, 0, 1, 5, 1, 256'h20, 1, 0));
    tbl.push_back(mk(I_W6, 0, 1, 6, 1, 256'h00, 1, 1));
    tbl.push_back(mk(I_W6, 0, 1, 7, 1, 256'h00, 1, 1));
    tbl.push_back(mk(I_W6, 0, 0, 3, 1, 256'h00, 0, 0));

    foreach (tbl[k]) begin
      cycle(tbl[k].r, tbl[k].v, 16'(tbl[k].idx));
      if (tbl[k].chk)
        expect_out($sformatf("vec%0d", k), tbl[k].inst, tbl[k].eo, tbl[k].ev, tbl[k].ee);
    end

    // WIDTH=40 (LAT=3): reset one cycle after idx 39 is accepted
    cycle(0, 1, 16'd5);
    cycle(0, 1, 16'd6);
    cycle(0, 1, 16'd39);
    expect_out("w40_idx5", I_W40, 256'h1 << 5, 1, 0);
    cycle(1, 0, 16'd0);
    expect_out("w40_rst", I_W40, 256'h0, 0, 0);
    cycle(0, 1, 16'd7);
    expect_out("w40_no39", I_W40, 256'h0, 0, 0);
    cycle(0, 0, 16'd39);
    expect_out("w40_gap", I_W40, 256'h0, 0, 0);
    cycle(0, 0, 16'd39);
    expect_out("w40_idx7", I_W40, 256'h1 << 7, 1, 0);
    cycle(0, 0, 16'd0);
    expect_out("w40_idle", I_W40, 256'h0, 0, 0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(63) == 0, $urandom_range(3) != 0, 16'($urandom));
    end
    for (int c = 0; c < 6; c++) cycle(0, 0, 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 Parameter: WIDTH, default 10, number of one-hot output lines (legal range 2..4096).
REQ-002 Derived constant: IW = clog2(WIDTH), index width; WIDTH=2 gives IW=1.
REQ-003 Derived constant: LAT, pipeline latency in cycles; LAT(W) = 1 if W <= 6, else 1 + LAT(ceil(W/6)).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  qualifies in_idx this cycle.
REQ-007 in_idx  input  IW  index of the line to assert.
REQ-008 out  output  WIDTH  one-hot decoded result, fully registered.
REQ-009 out_valid  output  1  out corresponds to an accepted input.
REQ-010 out_err  output  1  accepted input had in_idx >= WIDTH.

Function
REQ-011 Block shall be a free-running pipeline: no backpressure, one input accepted every cycle in_valid=1.
REQ-012 Input accepted at edge T shall appear on out/out_valid/out_err after edge T+LAT-1, i.e. visible in cycle T+LAT.
REQ-013 For valid in_idx < WIDTH: out[in_idx]=1, all other bits 0, out_valid=1, out_err=0.
REQ-014 For valid in_idx >= WIDTH (non-power-of-2 WIDTH): out=0, out_valid=1, out_err=1.
REQ-015 Cycles with in_valid=0 shall produce out=0, out_valid=0, out_err=0 LAT cycles later; in_idx ignored.
REQ-016 Structure for WIDTH <= 6: single register stage decoding in_idx directly.
REQ-017 Structure for WIDTH > 6: G = ceil(WIDTH/6) groups; group k owns lines 6k..6k+5 (lines >= WIDTH are padding, never driven high).
REQ-018 Group-select vector of width G shall be produced by a recursive pipe_decode instance with WIDTH=G, index in_idx/6, LAT(G) cycles.
REQ-019 Sub-index in_idx%6 and range-error flag shall be delayed LAT(G) cycles alongside the group-select path.
REQ-020 Final stage shall register out[6k+j] = group_sel[k] AND (delayed sub-index == j), out_valid, out_err.
REQ-021 No combinational path from any input to any output; every level bounded to one 6-input function per output bit.
REQ-022 Back-to-back inputs shall not interact; each pipeline slot carries its own index, valid, and error bit.
REQ-023 out shall never have more than one bit set in any cycle.

Reset
REQ-024 While rst=1 at an edge, all pipeline registers shall clear: out=0, out_valid=0, out_err=0 from the following cycle.
REQ-025 Inputs presented while rst=1 shall be discarded.
REQ-026 In-flight entries at reset assertion shall be discarded and never appear at the output.
REQ-027 First input accepted after rst deasserts shall emerge with normal latency LAT.
REQ-028 Recursive instances shall share clk and rst.

Verification
REQ-029 WIDTH=10 (LAT=2): in_valid=1, in_idx=7 at edge 0 -> edge 1 out=10'b0010000000, out_valid=1, out_err=0.
REQ-030 WIDTH=10: in_idx=12, in_valid=1 -> LAT cycles later out=0, out_valid=1, out_err=1.
REQ-031 WIDTH=10: in_idx 0, 9, 3 on consecutive cycles, in_valid=1 -> out 0x001, 0x200, 0x008 on consecutive cycles, out_valid held 1.
REQ-032 WIDTH=40 (LAT=3): inject idx 5, 6, 39; assert rst one cycle after idx 39 is accepted -> idx 39 never appears; out=0, out_valid=0 the cycle after rst; idx 7 accepted after reset emerges 3 cycles later as bit 7.
REQ-033 WIDTH=6 (LAT=1): sweep idx 0..7 with in_valid=1 -> one-hot for 0..5, out_err=1 with out=0 for 6 and 7.
REQ-034 Random sweep over WIDTH in {2, 6, 7, 36, 37, 216, 217}: output equals reference decode delayed by LAT; popcount(out) <= 1 every cycle.
